// File: rtl/peripheral_uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// line-control bit positions and the parity helper.
package peripheral_uart_pkg;

   localparam int UART_FIFO_REC_WIDTH = 11;

   localparam int UART_LC_BITS_LO = 0;
   localparam int UART_LC_BITS_HI = 1;
   localparam int UART_LC_SB      = 2;
   localparam int UART_LC_PE      = 3;
   localparam int UART_LC_EP      = 4;
   localparam int UART_LC_SP      = 5;

   typedef enum logic [2:0] {
      r_idle         = 3'd0,
      r_center_start = 3'd1,
      r_rec_bit      = 3'd2,
      r_rec_parity   = 3'd3,
      r_rec_stop     = 3'd4,
      r_push         = 3'd5
   } rstate_e;

   // Expected parity bit for the received data under {EP,SP}.
   function automatic logic uart_parity_exp(input logic [7:0] data,
                                            input logic ep,
                                            input logic sp);
      logic p;
      case ({ep, sp})
         2'b00:   p = ~^data;
         2'b01:   p = 1'b1;
         2'b10:   p = ^data;
         2'b11:   p = 1'b0;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/peripheral_uart_rfifo_wb.sv
// RX FIFO holding {data, parity_err, framing_err, break} records, with sticky
// overrun and an error summary over the currently valid entries.
module peripheral_uart_rfifo_wb
   import peripheral_uart_pkg::*;
#(
   parameter int FIFO_DEPTH     = 16,
   parameter int FIFO_POINTER_W = 4,
   parameter int FIFO_COUNTER_W = 5
)(
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic [UART_FIFO_REC_WIDTH-1:0] data_in,
   input  logic                           push,
   input  logic                           pop,
   input  logic                           fifo_reset,
   input  logic                           reset_status,
   output logic [UART_FIFO_REC_WIDTH-1:0] data_out,
   output logic                           overrun,
   output logic [FIFO_COUNTER_W-1:0]      count,
   output logic                           error_bit
);

   localparam logic [FIFO_COUNTER_W-1:0] FULL_COUNT = FIFO_COUNTER_W'(FIFO_DEPTH);
   localparam logic [FIFO_COUNTER_W-1:0] COUNT_ONE  = FIFO_COUNTER_W'(1);
   localparam logic [FIFO_POINTER_W-1:0] PTR_ONE    = FIFO_POINTER_W'(1);

   logic [UART_FIFO_REC_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [UART_FIFO_REC_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic [FIFO_POINTER_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx_s;
   logic [FIFO_COUNTER_W-1:0]      count_q, count_d;
   logic [UART_FIFO_REC_WIDTH-1:0] head_q, head_d;
   logic                           overrun_q, overrun_d, error_q, error_d;
   logic                           full_s, do_push_s, do_pop_s;

   // Next-state of storage, pointers, count and status.
   always_comb begin
      full_s    = (count_q == FULL_COUNT);
      do_pop_s  = pop & (count_q != '0) & ~fifo_reset;
      do_push_s = push & ~fifo_reset & (~full_s | do_pop_s);

      mem_d = mem_q;
      mem_d[wr_ptr_q] = do_push_s ? data_in : mem_q[wr_ptr_q];

      wr_ptr_d = fifo_reset ? '0 : (do_push_s ? wr_ptr_q + PTR_ONE : wr_ptr_q);
      rd_ptr_d = fifo_reset ? '0 : (do_pop_s  ? rd_ptr_q + PTR_ONE : rd_ptr_q);

      case ({fifo_reset, do_push_s, do_pop_s})
         3'b010:  count_d = count_q + COUNT_ONE;
         3'b001:  count_d = count_q - COUNT_ONE;
         3'b100, 3'b101, 3'b110, 3'b111: count_d = '0;
         default: count_d = count_q;
      endcase

      if (push & full_s & ~do_pop_s & ~fifo_reset) begin
         overrun_d = 1'b1;
      end else if (reset_status) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end

      head_d  = mem_d[rd_ptr_d];
      idx_s   = rd_ptr_d;
      error_d = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         idx_s   = rd_ptr_d + FIFO_POINTER_W'(i);
         error_d = error_d | ((FIFO_COUNTER_W'(i) < count_d) & (|mem_d[idx_s][2:0]));
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         head_q    <= '0;
         overrun_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         head_q    <= head_d;
         overrun_q <= overrun_d;
         error_q   <= error_d;
      end
   end

   assign data_out  = head_q;
   assign overrun   = overrun_q;
   assign count     = count_q;
   assign error_bit = error_q;

endmodule

// File: rtl/peripheral_uart_receiver_wb.sv
// UART receive half: synchronises srx, deframes characters on the 16x tick,
// pushes them with error flags into the RX FIFO and runs the character timeout.
module peripheral_uart_receiver_wb
   import peripheral_uart_pkg::*;
#(
   parameter int SIM            = 0,
   parameter int FIFO_DEPTH     = 16,
   parameter int FIFO_POINTER_W = 4,
   parameter int FIFO_COUNTER_W = 5
)(
   input  logic                           clk,
   input  logic                           wb_rst_i,
   input  logic [7:0]                     lcr,
   input  logic                           srx_pad_i,
   input  logic                           enable,
   input  logic                           rf_pop,
   input  logic                           rx_reset,
   input  logic                           lsr_mask,
   input  logic [9:0]                     toc_value,
   output logic [UART_FIFO_REC_WIDTH-1:0] rf_data_out,
   output logic [FIFO_COUNTER_W-1:0]      rf_count,
   output logic                           rf_overrun,
   output logic                           rf_error_bit,
   output logic [2:0]                     rstate,
   output logic [9:0]                     counter_t,
   output logic                           break_det
);

   localparam logic SIM_TICK = (SIM != 0);

   rstate_e                        state_q;
   logic                           srx_meta_q, srx_q;
   logic [3:0]                     tick_cnt_q;
   logic [2:0]                     bit_cnt_q;
   logic [7:0]                     data_q;
   logic                           parity_err_q, brk_q, break_det_q, push_q;
   logic [UART_FIFO_REC_WIDTH-1:0] push_data_q;
   logic [9:0]                     counter_t_q, counter_t_d;
   logic                           tick_s, brk_s, unused_s;
   logic [2:0]                     last_bit_s;

   assign tick_s     = enable | SIM_TICK;
   assign last_bit_s = 3'd4 + {1'b0, lcr[UART_LC_BITS_HI:UART_LC_BITS_LO]};
   assign brk_s      = (data_q == 8'h00) & ~srx_q;
   assign unused_s   = ^{lcr[7:6], lcr[UART_LC_SB]};

   // Two-flop synchroniser; idle line level is high.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         srx_meta_q <= 1'b1;
         srx_q      <= 1'b1;
      end else begin
         srx_meta_q <= srx_pad_i;
         srx_q      <= srx_meta_q;
      end
   end

   // Deframing FSM; only r_push advances without a tick.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= r_idle;
         tick_cnt_q   <= 4'd0;
         bit_cnt_q    <= 3'd0;
         data_q       <= 8'h00;
         parity_err_q <= 1'b0;
         brk_q        <= 1'b0;
         break_det_q  <= 1'b0;
         push_q       <= 1'b0;
         push_data_q  <= '0;
      end else begin
         push_q <= 1'b0;
         case (state_q)
            r_idle: begin
               if (tick_s) begin
                  if (break_det_q) begin
                     if (srx_q) break_det_q <= 1'b0;
                  end else if (!srx_q) begin
                     tick_cnt_q <= 4'd7;
                     state_q    <= r_center_start;
                  end
               end
            end
            r_center_start: begin
               if (tick_s) begin
                  if (tick_cnt_q != 4'd0) begin
                     tick_cnt_q <= tick_cnt_q - 4'd1;
                  end else if (srx_q) begin
                     state_q <= r_idle;
                  end else begin
                     tick_cnt_q   <= 4'd15;
                     bit_cnt_q    <= 3'd0;
                     data_q       <= 8'h00;
                     parity_err_q <= 1'b0;
                     state_q      <= r_rec_bit;
                  end
               end
            end
            r_rec_bit: begin
               if (tick_s) begin
                  if (tick_cnt_q != 4'd0) begin
                     tick_cnt_q <= tick_cnt_q - 4'd1;
                  end else begin
                     data_q[bit_cnt_q] <= srx_q;
                     tick_cnt_q        <= 4'd15;
                     bit_cnt_q         <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q == last_bit_s) begin
                        state_q <= lcr[UART_LC_PE] ? r_rec_parity : r_rec_stop;
                     end
                  end
               end
            end
            r_rec_parity: begin
               if (tick_s) begin
                  if (tick_cnt_q != 4'd0) begin
                     tick_cnt_q <= tick_cnt_q - 4'd1;
                  end else begin
                     parity_err_q <= srx_q != uart_parity_exp(data_q, lcr[UART_LC_EP],
                                                              lcr[UART_LC_SP]);
                     tick_cnt_q   <= 4'd15;
                     state_q      <= r_rec_stop;
                  end
               end
            end
            r_rec_stop: begin
               if (tick_s) begin
                  if (tick_cnt_q != 4'd0) begin
                     tick_cnt_q <= tick_cnt_q - 4'd1;
                  end else begin
                     push_q      <= 1'b1;
                     brk_q       <= brk_s;
                     push_data_q <= brk_s ? {8'h00, 1'b0, 1'b1, 1'b1}
                                          : {data_q, parity_err_q, ~srx_q, 1'b0};
                     state_q     <= r_push;
                  end
               end
            end
            r_push: begin
               break_det_q <= brk_q;
               state_q     <= r_idle;
            end
            default: state_q <= r_idle;
         endcase
      end
   end

   // Character timeout: reload on FIFO activity or when empty, else count ticks down.
   always_comb begin
      if (push_q | rf_pop | (rf_count == '0)) begin
         counter_t_d = toc_value;
      end else if (tick_s && (counter_t_q != 10'd0)) begin
         counter_t_d = counter_t_q - 10'd1;
      end else begin
         counter_t_d = counter_t_q;
      end
   end

   // Timeout register.
   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         counter_t_q <= 10'h3FF;
      end else begin
         counter_t_q <= counter_t_d;
      end
   end

   peripheral_uart_rfifo_wb #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .FIFO_POINTER_W (FIFO_POINTER_W),
      .FIFO_COUNTER_W (FIFO_COUNTER_W)
   ) u_rfifo (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .data_in      (push_data_q),
      .push         (push_q),
      .pop          (rf_pop),
      .fifo_reset   (rx_reset),
      .reset_status (lsr_mask),
      .data_out     (rf_data_out),
      .overrun      (rf_overrun),
      .count        (rf_count),
      .error_bit    (rf_error_bit)
   );

   assign rstate    = state_q;
   assign counter_t = counter_t_q;
   assign break_det = break_det_q;

endmodule

// File: tb/tb_peripheral_uart_receiver_wb.sv
// Scoreboard bench for the UART receiver: serial frames in, FIFO records out.
module tb_peripheral_uart_receiver_wb;
   import peripheral_uart_pkg::*;

   logic        clk = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [7:0]  lcr = 8'h03;
   logic        srx = 1'b1;
   logic        enable = 1'b0;
   logic        rf_pop = 1'b0;
   logic        rx_reset = 1'b0;
   logic        lsr_mask = 1'b0;
   logic [9:0]  toc_value = 10'd40;
   logic [10:0] rf_data_out;
   logic [4:0]  rf_count;
   logic        rf_overrun, rf_error_bit, break_det;
   logic [2:0]  rstate;
   logic [9:0]  counter_t;

   int          total = 0;
   int          bad = 0;
   logic [10:0] exp_q [$];
   logic [7:0]  d;

   peripheral_uart_receiver_wb #(.SIM(0)) dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .lcr          (lcr),
      .srx_pad_i    (srx),
      .enable       (enable),
      .rf_pop       (rf_pop),
      .rx_reset     (rx_reset),
      .lsr_mask     (lsr_mask),
      .toc_value    (toc_value),
      .rf_data_out  (rf_data_out),
      .rf_count     (rf_count),
      .rf_overrun   (rf_overrun),
      .rf_error_bit (rf_error_bit),
      .rstate       (rstate),
      .counter_t    (counter_t),
      .break_det    (break_det)
   );

   always #5 clk = ~clk;

   // 16x tick on every other clock, changing away from the active edge.
   always @(negedge clk) enable = ~enable;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!enable) @(posedge clk);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      srx = b;
      wait_ticks(16);
   endtask

   // Start, data and parity; leaves the line at the stop level.
   task automatic send_frame(input logic [7:0] data, input int nbits,
                             input logic par_en, input logic par_bit, input logic stop_b);
      drive_bit(1'b0);
      for (int i = 0; i < nbits; i++) drive_bit(data[i]);
      if (par_en) drive_bit(par_bit);
      @(negedge clk);
      srx = stop_b;
   endtask

   task automatic end_frame();
      wait_ticks(16);
      @(negedge clk);
      srx = 1'b1;
      wait_ticks(2);
   endtask

   task automatic wait_state(input logic [2:0] st, input string tag);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (rstate != st && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, rstate, st);
   endtask

   task automatic pop_check(input string tag);
      logic [10:0] e;
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
      chk(tag, rf_data_out, e);
      rf_pop = 1'b1;
      @(negedge clk);
      rf_pop = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", rstate, r_idle);
      chk("rst_count", rf_count, 0);
      chk("rst_overrun", rf_overrun, 0);
      chk("rst_errbit", rf_error_bit, 0);
      chk("rst_data", rf_data_out, 0);
      chk("rst_toc", counter_t, 10'h3FF);
      chk("rst_brk", break_det, 0);
      @(negedge clk);
      wb_rst_i = 1'b0;
      wait_ticks(4); #1;
      chk("toc_empty_hold", counter_t, 40);

      // 8N1 0xA5 with push timing
      exp_q.push_back({8'hA5, 3'b000});
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      wait_state(r_push, "t1_reach_push");
      chk("t1_stop_on_tick", enable, 1);
      chk("t1_cnt_before", rf_count, 0);
      @(posedge clk); #1;
      chk("t1_cnt_after", rf_count, 1);
      chk("t1_idle", rstate, r_idle);
      end_frame();
      pop_check("t1_data");
      chk("t1_empty", rf_count, 0);

      // 7E1 0x41 with wrong parity (even parity of 0x41 is 0)
      lcr = 8'h1A;
      exp_q.push_back({8'h41, 3'b100});
      send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
      end_frame();
      chk("t2_cnt", rf_count, 1);
      chk("t2_errbit", rf_error_bit, 1);
      pop_check("t2_data");
      chk("t2_errbit_clr", rf_error_bit, 0);

      // 5O1 0x16 with correct odd parity (three ones -> parity 0)
      lcr = 8'h08;
      exp_q.push_back({8'h16, 3'b000});
      send_frame(8'h16, 5, 1'b1, 1'b0, 1'b1);
      end_frame();
      chk("t2b_errbit", rf_error_bit, 0);
      pop_check("t2b_data");

      // short start pulse
      lcr = 8'h03;
      @(negedge clk);
      srx = 1'b0;
      wait_ticks(4); #1;
      chk("t3_in_start", rstate, r_center_start);
      @(negedge clk);
      srx = 1'b1;
      wait_ticks(20); #1;
      chk("t3_idle", rstate, r_idle);
      chk("t3_cnt", rf_count, 0);

      // break: line low for two character times
      exp_q.push_back(11'h003);
      send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
      wait_ticks(176); #1;
      chk("t4_cnt", rf_count, 1);
      chk("t4_brk", break_det, 1);
      chk("t4_state", rstate, r_idle);
      @(negedge clk);
      srx = 1'b1;
      wait_ticks(3); #1;
      chk("t4_brk_clr", break_det, 0);
      exp_q.push_back({8'h55, 3'b000});
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
      end_frame();
      chk("t4_cnt2", rf_count, 2);
      pop_check("t4_break_entry");
      pop_check("t4_55");

      // overrun: 17 characters, last one dropped
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom_range(0, 255));
         if (i < 16) exp_q.push_back({d, 3'b000});
         send_frame(d, 8, 1'b0, 1'b0, 1'b1);
         end_frame();
      end
      chk("t5_full", rf_count, 16);
      chk("t5_overrun", rf_overrun, 1);
      chk("t5_errbit", rf_error_bit, 0);
      @(negedge clk);
      lsr_mask = 1'b1;
      @(negedge clk);
      lsr_mask = 1'b0;
      chk("t5_overrun_clr", rf_overrun, 0);

      // push and pop in the same cycle while full
      d = 8'($urandom_range(0, 255));
      send_frame(d, 8, 1'b0, 1'b0, 1'b1);
      wait_state(r_push, "t5_push_state");
      chk("t5_head", rf_data_out, exp_q.pop_front());
      exp_q.push_back({d, 3'b000});
      rf_pop = 1'b1;
      @(posedge clk); #1;
      rf_pop = 1'b0;
      chk("t5_pp_cnt", rf_count, 16);
      chk("t5_pp_overrun", rf_overrun, 0);
      end_frame();

      send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1);
      end_frame();
      chk("t5_overrun2", rf_overrun, 1);
      for (int i = 0; i < 14; i++) pop_check("t5_drain");
      chk("t5_cnt2", rf_count, 2);
      @(negedge clk);
      rx_reset = 1'b1;
      @(negedge clk);
      rx_reset = 1'b0;
      exp_q.delete();
      chk("t5_rxreset_cnt", rf_count, 0);
      chk("t5_rxreset_ovr", rf_overrun, 1);
      @(negedge clk);
      lsr_mask = 1'b1;
      rf_pop = 1'b1;
      @(negedge clk);
      lsr_mask = 1'b0;
      rf_pop = 1'b0;
      chk("t5_empty_pop", rf_count, 0);
      chk("t5_ovr_clr2", rf_overrun, 0);

      // character timeout
      wait_ticks(5); #1;
      chk("t6_hold_empty", counter_t, 40);
      exp_q.push_back({8'h3C, 3'b000});
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
      wait_state(r_push, "t6_push_state");
      @(posedge clk); #1;
      chk("t6_cnt", rf_count, 1);
      chk("t6_reload", counter_t, 40);
      wait_ticks(39); #1;
      chk("t6_toc_1", counter_t, 1);
      wait_ticks(1); #1;
      chk("t6_toc_0", counter_t, 0);
      wait_ticks(5); #1;
      chk("t6_toc_sat", counter_t, 0);
      pop_check("t6_data");
      chk("t6_pop_reload", counter_t, 40);
      wait_ticks(10); #1;
      chk("t6_empty_hold", counter_t, 40);

      // reset in the middle of a character
      @(negedge clk);
      srx = 1'b0;
      wait_ticks(40); #1;
      chk("t7_busy", rstate, r_rec_bit);
      @(negedge clk);
      wb_rst_i = 1'b1;
      @(negedge clk);
      chk("t7_rst_state", rstate, r_idle);
      srx = 1'b1;
      wb_rst_i = 1'b0;
      wait_ticks(200); #1;
      chk("t7_idle", rstate, r_idle);
      chk("t7_no_push", rf_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
